// File: rtl/avg_pool_accum.sv
// Average-pool front end: sums POOL_SIZE signed samples, hands the sum to an
// external divider, saturates the quotient and offers it on a valid/ready port.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ACCUM    | accepting samples, accumulating the window sum
// DIV_REQ  | one-cycle divide request to the divider
// DIV_WAIT | operands held steady, waiting for the quotient pulse
// OUTPUT   | averaged value presented until the consumer takes it
module avg_pool_accum #(
  parameter int IN_WIDTH           = 16,
  parameter int OUT_WIDTH          = 16,
  parameter int POOL_SIZE          = 49,
  parameter int ACC_WIDTH          = 32,
  parameter int DIV_DIVIDEND_WIDTH = 64,
  parameter int DIV_DIVISOR_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  output logic                          in_ready,
  output logic                          div_valid_in,
  output logic [DIV_DIVIDEND_WIDTH-1:0] div_dividend,
  output logic [DIV_DIVISOR_WIDTH-1:0]  div_divisor,
  input  logic [DIV_DIVIDEND_WIDTH-1:0] div_quotient,
  input  logic                          div_valid_out,
  input  logic                          div_overflow,
  output logic                          out_valid,
  output logic [OUT_WIDTH-1:0]          out_data,
  input  logic                          out_ready,
  output logic                          err
);

  localparam int CNT_W = $clog2(POOL_SIZE);
  localparam int DDW   = DIV_DIVIDEND_WIDTH;

  localparam logic [CNT_W-1:0]             CNT_LAST = CNT_W'(POOL_SIZE - 1);
  localparam logic [DIV_DIVISOR_WIDTH-1:0] DIVISOR  = DIV_DIVISOR_WIDTH'(POOL_SIZE);

  // Saturation bounds, both as full-width signed values for the compare and
  // as output-width patterns for the clamped result.
  localparam logic signed [DDW-1:0] SAT_MAX = {{(DDW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [DDW-1:0] SAT_MIN = {{(DDW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]  OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]  OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_DIV_REQ  = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_OUTPUT   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DDW-1:0]           dividend_q, dividend_d;
  logic [DIV_DIVISOR_WIDTH-1:0] divisor_q;
  logic [OUT_WIDTH-1:0]     out_q, out_d;
  logic                     err_q, err_d;

  logic [ACC_WIDTH-1:0]     in_sext;
  logic signed [DDW-1:0]    quot_s;
  logic [OUT_WIDTH-1:0]     quot_sat;

  assign in_sext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign quot_s  = div_quotient;

  // Clamp the divider result into the signed output range.
  always_comb begin
    quot_sat = quot_s[OUT_WIDTH-1:0];
    if (quot_s > SAT_MAX) begin
      quot_sat = OUT_MAX;
    end else if (quot_s < SAT_MIN) begin
      quot_sat = OUT_MIN;
    end
  end

  // Next-state and datapath update for the window sequencer.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    out_d      = out_q;
    err_d      = err_q;
    unique case (state_q)
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + in_sext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Final sum goes straight to the operand register so the request
            // cycle already presents it.
            dividend_d = {{(DDW-ACC_WIDTH){acc_d[ACC_WIDTH-1]}}, acc_d};
            state_d    = ST_DIV_REQ;
          end
        end
      end
      ST_DIV_REQ: begin
        state_d = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: begin
        if (div_valid_out) begin
          if (div_overflow) begin
            out_d = '0;
            err_d = 1'b1;
          end else begin
            out_d = quot_sat;
          end
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  // Divisor is a constant, but kept in a flop so the divider sees a registered operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor_q <= DIVISOR;
    end else begin
      divisor_q <= DIVISOR;
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign div_valid_in = (state_q == ST_DIV_REQ);
  assign out_valid    = (state_q == ST_OUTPUT);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_data     = out_q;
  assign err          = err_q;

endmodule

// File: tb/tb_avg_pool_accum.sv
// Bench for avg_pool_accum: table windows, hand sequences for handshake,
// reset and overflow corners, random windows against an arithmetic model,
// and a narrow-output instance for saturation.
module tb_avg_pool_accum;

  localparam int POOL = 49;
  localparam int LAT  = 5;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Main instance (16-bit output, 5-cycle divider model)
  logic        in_valid, in_ready, div_valid_in, div_valid_out, div_overflow;
  logic [15:0] in_data, out_data;
  logic [63:0] div_dividend, div_quotient;
  logic [31:0] div_divisor;
  logic        out_valid, out_ready, err;
  logic        spur, ovf_inject;

  avg_pool_accum dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_valid_out(div_valid_out), .div_overflow(div_overflow),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .err(err));

  logic [LAT-1:0] dsr;
  logic [63:0]    dq;
  // Divider model: truncating signed divide, result pulses LAT cycles after the request.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dsr <= '0;
      dq  <= '0;
    end else begin
      dsr <= {dsr[LAT-2:0], div_valid_in};
      if (div_valid_in) dq <= $signed(div_dividend) / $signed({32'd0, div_divisor});
    end
  end
  assign div_valid_out = dsr[LAT-1] | spur;
  assign div_overflow  = ovf_inject;
  assign div_quotient  = dq;

  // Narrow-output instance (8-bit output, 1-cycle divider model)
  logic        in_valid8, in_ready8, div_valid_in8, div_valid_out8, out_valid8, out_ready8, err8;
  logic [15:0] in_data8;
  logic [7:0]  out_data8;
  logic [63:0] div_dividend8, dq8;
  logic [31:0] div_divisor8;

  avg_pool_accum #(.OUT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .div_valid_in(div_valid_in8), .div_dividend(div_dividend8), .div_divisor(div_divisor8),
    .div_quotient(dq8), .div_valid_out(div_valid_out8), .div_overflow(1'b0),
    .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8), .err(err8));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_valid_out8 <= 1'b0;
      dq8            <= '0;
    end else begin
      div_valid_out8 <= div_valid_in8;
      if (div_valid_in8) dq8 <= $signed(div_dividend8) / $signed({32'd0, div_divisor8});
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int win_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: window mean truncated toward zero, clamped to the output width.
  function automatic longint model_avg(input longint pre, input int ow);
    longint s = pre;
    longint a, hi, lo;
    foreach (win_q[i]) s += win_q[i];
    a  = s / POOL;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (a > hi) a = hi;
    if (a < lo) a = lo;
    return a;
  endfunction

  task automatic send_sample(input int v);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(v);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready wait timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Feed win_q, then check operands, request pulse count and request-to-valid latency.
  // Returns at the negedge where out_valid is first seen.
  task automatic feed_and_wait(input string nm, input longint pre, input bit gaps);
    longint sum = pre;
    int t = 0;
    int pulses = 0;
    foreach (win_q[i]) begin
      sum += win_q[i];
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_sample(win_q[i]);
    end
    @(negedge clk);
    check({nm, " dividend"}, $signed(div_dividend), sum);
    check({nm, " divisor"}, div_divisor, POOL);
    while (!out_valid && t < 100) begin
      if (div_valid_in) pulses++;
      if (in_ready) check({nm, " in_ready during divide"}, in_ready, 0);
      @(negedge clk);
      t++;
    end
    check({nm, " req pulses"}, pulses, 1);
    check({nm, " req-to-valid cycles"}, t, LAT + 1);
  endtask

  task automatic run_window(input string nm, input longint pre, input longint exp_out,
                            input bit exp_err, input int rdy_delay, input bit gaps);
    feed_and_wait(nm, pre, gaps);
    check({nm, " out_data"}, $signed(out_data), exp_out);
    check({nm, " err"}, err, exp_err);
    repeat (rdy_delay) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " back to accum"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic fill(input int first, input int rest, input int n);
    win_q.delete();
    win_q.push_back(first);
    for (int i = 1; i < n; i++) win_q.push_back(rest);
  endtask

  typedef struct {
    string  nm;
    int     first;
    int     rest;
    longint exp;
  } vec_t;

  vec_t tbl[8];
  vec_t tbl8[5];

  initial begin
    tbl[0] = '{"all +10",        10,     10,     10};
    tbl[1] = '{"+100 then 0",    100,    0,      2};
    tbl[2] = '{"-100 then 0",    -100,   0,      -2};
    tbl[3] = '{"-1 then 0",      -1,     0,      0};
    tbl[4] = '{"all -7",         -7,     -7,     -7};
    tbl[5] = '{"all max",        32767,  32767,  32767};
    tbl[6] = '{"all min",        -32768, -32768, -32768};
    tbl[7] = '{"+48 then +1",    48,     1,      1};
    tbl8[0] = '{"w8 +200", 200,  200,  127};
    tbl8[1] = '{"w8 -200", -200, -200, -128};
    tbl8[2] = '{"w8 +128", 128,  128,  127};
    tbl8[3] = '{"w8 -129", -129, -129, -128};
    tbl8[4] = '{"w8 +127", 127,  127,  127};

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; spur = 1'b0; ovf_inject = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst div_valid_in", div_valid_in, 0);
    check("rst div_dividend", div_dividend, 0);
    check("rst div_divisor", div_divisor, POOL);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst err", err, 0);
    reset = 1'b0;

    // Stray divider pulse (even with overflow) in ACCUM is ignored.
    @(negedge clk);
    spur = 1'b1; ovf_inject = 1'b1;
    @(negedge clk);
    spur = 1'b0; ovf_inject = 1'b0;
    check("stray div pulse", {out_valid, in_ready, err}, 3'b010);

    foreach (tbl[k]) begin
      fill(tbl[k].first, tbl[k].rest, POOL);
      run_window(tbl[k].nm, 0, tbl[k].exp, 1'b0, k % 3, 1'b0);
    end

    // Consumer stalls 5 cycles; a sample offered meanwhile belongs to the next window.
    fill(20, 20, POOL);
    feed_and_wait("hold", 0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd49;
    for (int i = 0; i < 5; i++) begin
      check("hold stable", {out_valid, in_ready, out_data}, {2'b10, 16'd20});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fill(0, 0, POOL - 1);
    run_window("after hold", 49, 1, 1'b0, 0, 1'b0);

    // out_ready already high before OUTPUT: handshake in the first OUTPUT cycle.
    out_ready = 1'b1;
    fill(-7, -7, POOL);
    feed_and_wait("ready high", 0, 1'b0);
    check("ready high out_data", $signed(out_data), -7);
    @(posedge clk);
    #1;
    check("ready high one cycle", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;

    // Divider overflow: zero result, sticky err across a good window.
    ovf_inject = 1'b1;
    fill(10, 10, POOL);
    run_window("overflow", 0, 0, 1'b1, 1, 1'b0);
    ovf_inject = 1'b0;
    fill(10, 10, POOL);
    run_window("after overflow", 0, 10, 1'b1, 0, 1'b0);

    // Reset mid-window discards the partial sum and clears err.
    for (int i = 0; i < 20; i++) send_sample(1000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset async", {in_ready, out_valid, err, div_dividend}, {3'b100, 64'd0});
    @(negedge clk);
    reset = 1'b0;
    fill(3, 3, POOL);
    run_window("after mid reset", 0, 3, 1'b0, 0, 1'b0);

    // Reset while a divide is in flight: no stale result afterwards.
    for (int i = 0; i < POOL; i++) send_sample(5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) seen++;
        @(negedge clk);
      end
      check("no stale result", seen, 0);
    end
    fill(7, 7, POOL);
    run_window("after divide reset", 0, 7, 1'b0, 0, 1'b0);

    // Random windows against the arithmetic model.
    for (int w = 0; w < 10; w++) begin
      win_q.delete();
      for (int i = 0; i < POOL; i++) begin
        if (w % 2 == 0) win_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        else            win_q.push_back(int'($urandom_range(0, 400)) - 200);
      end
      run_window("random", 0, model_avg(0, 16), 1'b0, $urandom_range(0, 3), 1'b1);
    end

    // Saturation on the narrow-output instance.
    foreach (tbl8[k]) begin
      int t = 0;
      @(negedge clk);
      in_valid8 = 1'b1;
      in_data8  = 16'(tbl8[k].first);
      repeat (POOL) @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      while (!out_valid8 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check(tbl8[k].nm, $signed(out_data8), tbl8[k].exp);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
